// File: rtl/mtl2_clkgen_bank.sv
// Multi-channel clock-enable / divided-strobe generator gated on a settled, synchronised PLL lock.
// Optional `MTL2_CLKGEN_LOSS_CNT_EN adds an 8-bit saturating lock-loss counter output (loss_cnt).
module mtl2_clkgen_bank #(
    parameter int                NUM_CH     = 4,
    parameter int                CNT_W      = 16,
    parameter int                SETTLE_CYC = 1024,
    parameter logic [CNT_W-1:0]  DIV_INIT   = CNT_W'(6),
    parameter int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_div,
    output logic              running,
    output logic              lock_sync
`ifdef MTL2_CLKGEN_LOSS_CNT_EN
    ,
    output logic [7:0]        loss_cnt
`endif
);

    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] SETTLE    = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [SC_W-1:0] settle_q, settle_d;
    logic            sync1_q, lock_sync_q, running_q;
    logic            run_adv, run_entry;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (!lock_sync_q) begin
                    state_d = WAIT_LOCK;
                end else if (settle_q == SC_W'(SETTLE_CYC - 1)) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + SC_W'(1);
                end
            end
            RUN: begin
                if (!lock_sync_q) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Channels only advance in RUN cycles that keep lock; the lock-loss cycle already holds.
    assign run_adv   = (state_q == RUN) && lock_sync_q;
    assign run_entry = (state_q != RUN) && (state_d == RUN);

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            settle_q    <= '0;
            sync1_q     <= 1'b0;
            lock_sync_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            sync1_q     <= pll_locked;
            lock_sync_q <= sync1_q;
            running_q   <= run_adv;
        end
    end

    assign running   = running_q;
    assign lock_sync = lock_sync_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] div_q, div_d, sdiv_q, sdiv_d, sph_q, sph_d, cnt_q, cnt_d;
        logic [CNT_W-1:0] load_ph;
        logic [CNT_W:0]   half;
        logic             pend_q, pend_d, en_q, en_d, dv_q, dv_d;
        logic             hit, at_end;

        assign hit     = cfg_wr && (cfg_ch == CH_W'(gi));
        assign load_ph = (sph_q < sdiv_q) ? sph_q : '0;
        assign at_end  = (cnt_q == div_q - CNT_W'(1));
        assign half    = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;

        always_comb begin
            div_d  = div_q;
            cnt_d  = cnt_q;
            pend_d = pend_q | hit;
            sdiv_d = hit ? cfg_div : sdiv_q;
            sph_d  = hit ? cfg_phase : sph_q;
            en_d   = 1'b0;
            dv_d   = 1'b0;
            if (run_adv && (div_q != '0)) begin
                en_d = at_end;
                dv_d = ({1'b0, cnt_q} < half);
                if (at_end) begin
                    // A write landing on the wrap cycle waits for the following wrap.
                    cnt_d  = '0;
                    pend_d = hit;
                    if (pend_q) begin
                        div_d = sdiv_q;
                        cnt_d = load_ph;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                div_d  = sdiv_q;
                pend_d = hit;
                if (run_adv || run_entry) cnt_d = load_ph;
            end
        end

        always_ff @(posedge refclk) begin
            if (!rst_n) begin
                div_q  <= DIV_INIT;
                sdiv_q <= DIV_INIT;
                sph_q  <= '0;
                cnt_q  <= '0;
                pend_q <= 1'b0;
                en_q   <= 1'b0;
                dv_q   <= 1'b0;
            end else begin
                div_q  <= div_d;
                sdiv_q <= sdiv_d;
                sph_q  <= sph_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                en_q   <= en_d;
                dv_q   <= dv_d;
            end
        end

        assign clk_en[gi]  = en_q;
        assign clk_div[gi] = dv_q;
    end

`ifdef MTL2_CLKGEN_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if ((state_q == RUN) && !lock_sync_q && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule
